instr_fetch_queue: RTL and testbench
====================================

# instr_fetch_queue

Parametrised instruction fetch queue between fetch and decode. Generalises the single 8-bit instruction register into a DEPTH-entry circular buffer of IW-bit instruction words, each tagged with its second-fetch flag (sf1). Valid/ready handshakes on both sides let fetch run ahead of a stalled decode; a synchronous flush discards all buffered words on a taken branch or interrupt.

## Interface
- IW, 8: instruction word width in bits.
- DEPTH, 4: number of entries; power of two, ≥ 2.
- CW, $clog2(DEPTH+1): derived occupancy width; not overridden.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of all entries; ignored while rst is high.
- push_valid  in  1  fetch presents a word.
- push_ready  out  1  queue accepts a word; equals !full.
- push_instr  in  IW  incoming instruction word.
- push_sf1  in  1  incoming second-fetch tag.
- pop_valid  out  1  head entry valid; equals !empty, or the bypass term when TIQ_BYPASS_EN is defined.
- pop_ready  in  1  decode consumes head.
- pop_instr  out  IW  head word; all zeros when pop_valid is 0.
- pop_sf1  out  1  head tag; 0 when pop_valid is 0.
- count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × (IW+1) array holding {sf1, instr}.
- Pointers: rd_ptr and wr_ptr are each log2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - empty = (rd_ptr == wr_ptr).
  - full = index bits equal and wrap bits differ.
- Push fires on push_valid && push_ready. It writes mem[wr_ptr index] and increments wr_ptr modulo 2·DEPTH.
- Pop fires on pop_valid && pop_ready. It increments rd_ptr. Pop data is the combinational read of mem[rd_ptr index], gated to zero when the queue is empty.
- Simultaneous push and pop:
  - Not full and not empty: both fire; count is unchanged.
  - Full: push_ready is 0, so only the pop fires. No combinational ready path from pop_ready to push_ready.
  - Empty without bypass: only the push fires.
- count increments on push-only, decrements on pop-only, and is unchanged otherwise. It never exceeds DEPTH and never underflows.
- Flush: at the next edge, pointers and count go to 0.
  - A push or pop presented in the same cycle is discarded and has no effect.
  - Array contents are don't-care after flush.
- Priority: rst > flush > push/pop.
- Input values are don't-care when push_valid is 0.

## Timing
- Reset values: push_ready = 1, pop_valid = 0, pop_instr = 0, pop_sf1 = 0, count = 0, rd_ptr = wr_ptr = 0.
- Reset asserted mid-operation empties the queue at that edge. Held data is lost.
- Latency without bypass: a word pushed at edge N appears on pop_* in the cycle after edge N (1 cycle).
- Throughput: 1 push and 1 pop per cycle in steady state.
- After flush at edge N: pop_valid = 0 and push_ready = 1 in cycle N+1.
- Wrap-around: after 2·DEPTH pushes and pops, the pointers return to 0 with no bubble.

## Configuration
- TIQ_BYPASS_EN defined:
  - When empty and push_valid is 1: pop_valid = 1 combinationally, and pop_instr/pop_sf1 = push_instr/push_sf1.
  - If pop_ready is also 1, the word passes through without being written, and pointers and count are unchanged (0-cycle latency).
  - If pop_ready is 0, the word is written normally.
  - Flush suppresses the bypass term.
- TIQ_BYPASS_EN undefined: no combinational path from push_* to pop_*. Minimum latency is 1 cycle.

## Structure
- Shared package tiq_pkg: default IW/DEPTH constants and a packed struct tiq_entry_t {logic sf1; logic [IW-1:0] instr;}.
- One sub-module, tiq_ptr: wrap-bit pointer counter with inputs clk, rst, clr, inc and output ptr. Instantiated twice, as rd and wr. clr is driven by flush.

## Test plan
- Reset: assert rst for 2 cycles with push_valid = 1 → count = 0, pop_valid = 0, pop_instr = 0x00, push_ready = 1.
- Fill (DEPTH = 4): push 0x11, 0x22, 0x33, 0x44 with pop_ready = 0 → count = 4, push_ready = 0. A 5th push of 0x55 is refused. Popping then returns 0x11, 0x22, 0x33, 0x44 in order.
- Streaming: push and pop every cycle for 20 words, 0x01–0x14, with sf1 alternating → output order and tags match, count stays 1, pointers wrap cleanly.
- Flush: with 3 entries held, assert flush together with a push of 0xAA and pop_ready = 1 → next cycle count = 0, pop_valid = 0, and 0xAA never appears at the output.
- Full with simultaneous pop: at count = 4, push_valid = 1 and pop_ready = 1 → only the pop fires, count = 3, and the pushed word is accepted in the following cycle.
- Bypass (macro defined): empty queue, push 0x5A with sf1 = 1 and pop_ready = 1 → pop_valid = 1, pop_instr = 0x5A, pop_sf1 = 1 in the same cycle, count stays 0. With the macro undefined, the same stimulus yields the word one cycle later.

Source files
------------

// File: rtl/tiq_pkg.sv
// Shared defaults and entry layout for the instruction fetch queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tiq_pkg;

  // Default instruction word width and queue depth.
  localparam int TIQ_IW    = 8;
  localparam int TIQ_DEPTH = 4;

  // One stored queue entry: second-fetch tag above the instruction word.
  typedef struct packed {
    logic              sf1;
    logic [TIQ_IW-1:0] instr;
  } tiq_entry_t;

endpackage

// File: rtl/tiq_ptr.sv
// Wrap-bit pointer counter for the fetch queue; MSB is the lap (wrap) bit.
// Latency: new pointer value visible the cycle after inc/clr.
// Backpressure: none; the caller only asserts inc when a transfer fires.
module tiq_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Next pointer: clear wins over increment; natural overflow gives modulo 2*DEPTH.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  // Pointer register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {sf1, instr} between fetch and decode.
// Latency: 1 cycle push-to-pop; 0 cycles through the empty-queue bypass when TIQ_BYPASS_EN is defined.
// Backpressure: push_ready = !full (no path from pop_ready); flush discards all entries and same-cycle transfers.
module instr_fetch_queue
  import tiq_pkg::*;
#(
  parameter int IW    = TIQ_IW,
  parameter int DEPTH = TIQ_DEPTH,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_valid,
  output logic          push_ready,
  input  logic [IW-1:0] push_instr,
  input  logic          push_sf1,
  output logic          pop_valid,
  input  logic          pop_ready,
  output logic [IW-1:0] pop_instr,
  output logic          pop_sf1,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Entry layout sized by this instance's IW (matches tiq_entry_t at default width).
  typedef struct packed {
    logic          sf1;
    logic [IW-1:0] instr;
  } entry_t;

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          push_fire;
  logic          pop_fire;
  logic          byp_take;
  entry_t        head;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign head  = mem_q[rd_ptr[AW-1:0]];

  assign push_ready = !full;

  // Head presentation: stored word when non-empty, optional pass-through when empty, else zeros.
  always_comb begin
    pop_valid = !empty;
    pop_instr = '0;
    pop_sf1   = 1'b0;
    byp_take  = 1'b0;
    if (!empty) begin
      pop_instr = head.instr;
      pop_sf1   = head.sf1;
    end
`ifdef TIQ_BYPASS_EN
    else if (push_valid && !flush && !rst) begin
      pop_valid = 1'b1;
      pop_instr = push_instr;
      pop_sf1   = push_sf1;
      byp_take  = pop_ready;
    end
`endif
  end

  // A bypassed word is consumed directly and never stored; flush kills both sides.
  assign push_fire = push_valid && !full && !byp_take && !flush;
  assign pop_fire  = !empty && pop_ready && !flush;

  // Storage write on an accepted push.
  always_comb begin
    mem_d = mem_q;
    if (push_fire) begin
      mem_d[wr_ptr[AW-1:0]] = '{sf1: push_sf1, instr: push_instr};
    end
  end

  // Storage array; contents are don't-care while not covered by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Occupancy update: flush clears, push-only adds, pop-only removes.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push_fire && !pop_fire) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (pop_fire && !push_fire) begin
      count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // Occupancy register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

  tiq_ptr #(.PW(PW)) u_rd (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop_fire),
    .ptr (rd_ptr)
  );

  tiq_ptr #(.PW(PW)) u_wr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push_fire),
    .ptr (wr_ptr)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed vector bench for instr_fetch_queue (DEPTH=4, IW=8), both with and without TIQ_BYPASS_EN.
// Inputs are driven at the falling edge; outputs are compared 1 ns later, before the committing rising edge.
// Expected values are hand-derived from the queue behaviour, with bypass-dependent fields selected by BYP.
module tb_instr_fetch_queue;

`ifdef TIQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       push_valid = 1'b0;
  logic       push_ready;
  logic [7:0] push_instr = '0;
  logic       push_sf1 = 1'b0;
  logic       pop_valid;
  logic       pop_ready = 1'b0;
  logic [7:0] pop_instr;
  logic       pop_sf1;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.IW(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_instr (push_instr),
    .push_sf1   (push_sf1),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_instr  (pop_instr),
    .pop_sf1    (pop_sf1),
    .count      (count)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       pv;
    logic [7:0] pi;
    logic       ps;
    logic       pr;
    bit         chk;
    logic       e_prdy;
    logic       e_pvld;
    logic [7:0] e_pi;
    logic       e_ps;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void v(input logic r, input logic f, input logic pv, input logic [7:0] pi,
                            input logic ps, input logic pr, input bit c, input logic e_prdy,
                            input logic e_pvld, input logic [7:0] e_pi, input logic e_ps,
                            input logic [2:0] e_cnt);
    vec_t t;
    t.rst = r; t.flush = f; t.pv = pv; t.pi = pi; t.ps = ps; t.pr = pr; t.chk = c;
    t.e_prdy = e_prdy; t.e_pvld = e_pvld; t.e_pi = e_pi; t.e_ps = e_ps; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_prdy, input logic e_pvld,
                           input logic [7:0] e_pi, input logic e_ps, input logic [2:0] e_cnt);
    cmp("push_ready", idx, {31'b0, push_ready}, {31'b0, e_prdy});
    cmp("pop_valid",  idx, {31'b0, pop_valid},  {31'b0, e_pvld});
    cmp("pop_instr",  idx, {24'b0, pop_instr},  {24'b0, e_pi});
    cmp("pop_sf1",    idx, {31'b0, pop_sf1},    {31'b0, e_ps});
    cmp("count",      idx, {29'b0, count},      {29'b0, e_cnt});
  endtask

  task automatic drive(input logic r, input logic f, input logic pv, input logic [7:0] pi,
                       input logic ps, input logic pr);
    @(negedge clk);
    rst = r; flush = f; push_valid = pv; push_instr = pi; push_sf1 = ps; pop_ready = pr;
    #1;
  endtask

  initial begin
    // Reset held two cycles with a push presented
    v(1,0,1,8'h77,0,0, 0, 0,0,8'h00,0,0);
    v(1,0,1,8'h77,0,0, 1, 1,0,8'h00,0,0);
    // Fill four, refuse a fifth, then drain in order
    v(0,0,1,8'h11,0,0, 1, 1,BYP,BYP ? 8'h11 : 8'h00,0,0);
    v(0,0,1,8'h22,1,0, 1, 1,1,8'h11,0,1);
    v(0,0,1,8'h33,0,0, 1, 1,1,8'h11,0,2);
    v(0,0,1,8'h44,1,0, 1, 1,1,8'h11,0,3);
    v(0,0,1,8'h55,0,0, 1, 0,1,8'h11,0,4);
    v(0,0,0,8'h00,0,1, 1, 0,1,8'h11,0,4);
    v(0,0,0,8'h00,0,1, 1, 1,1,8'h22,1,3);
    v(0,0,0,8'h00,0,1, 1, 1,1,8'h33,0,2);
    v(0,0,0,8'h00,0,1, 1, 1,1,8'h44,1,1);
    v(0,0,0,8'h00,0,0, 1, 1,0,8'h00,0,0);
    // Full with simultaneous pop: only the pop fires, the push lands next cycle
    v(0,0,1,8'hA1,1,0, 1, 1,BYP,BYP ? 8'hA1 : 8'h00,BYP,0);
    v(0,0,1,8'hA2,0,0, 1, 1,1,8'hA1,1,1);
    v(0,0,1,8'hA3,0,0, 1, 1,1,8'hA1,1,2);
    v(0,0,1,8'hA4,0,0, 1, 1,1,8'hA1,1,3);
    v(0,0,1,8'hA5,1,1, 1, 0,1,8'hA1,1,4);
    v(0,0,1,8'hA5,1,0, 1, 1,1,8'hA2,0,3);
    v(0,0,0,8'h00,0,0, 1, 0,1,8'hA2,0,4);
    v(0,0,0,8'h00,0,1, 1, 0,1,8'hA2,0,4);
    v(0,0,0,8'h00,0,1, 1, 1,1,8'hA3,0,3);
    v(0,0,0,8'h00,0,1, 1, 1,1,8'hA4,0,2);
    v(0,0,0,8'h00,0,1, 1, 1,1,8'hA5,1,1);
    v(0,0,0,8'h00,0,0, 1, 1,0,8'h00,0,0);
    // Flush with three held, a push of 0xAA and pop_ready in the same cycle
    v(0,0,1,8'hB1,0,0, 1, 1,BYP,BYP ? 8'hB1 : 8'h00,0,0);
    v(0,0,1,8'hB2,1,0, 1, 1,1,8'hB1,0,1);
    v(0,0,1,8'hB3,0,0, 1, 1,1,8'hB1,0,2);
    v(0,1,1,8'hAA,1,1, 1, 1,1,8'hB1,0,3);
    v(0,0,0,8'h00,0,0, 1, 1,0,8'h00,0,0);
    v(0,0,0,8'h00,0,1, 1, 1,0,8'h00,0,0);
    // Flush on an empty queue suppresses the bypass and discards the push
    v(0,1,1,8'hC1,1,1, 1, 1,0,8'h00,0,0);
    v(0,0,0,8'h00,0,0, 1, 1,0,8'h00,0,0);
    // Reset mid-operation drops held data
    v(0,0,1,8'hD1,0,0, 1, 1,BYP,BYP ? 8'hD1 : 8'h00,0,0);
    v(1,0,1,8'hD2,0,0, 1, 1,1,8'hD1,0,1);
    v(0,0,0,8'h00,0,0, 1, 1,0,8'h00,0,0);
    // Empty queue, push 0x5A with pop_ready: same cycle with bypass, next cycle without
    v(0,0,1,8'h5A,1,1, 1, 1,BYP,BYP ? 8'h5A : 8'h00,BYP,0);
    v(0,0,0,8'h00,0,1, 1, 1,!BYP,BYP ? 8'h00 : 8'h5A,!BYP,BYP ? 3'd0 : 3'd1);
    v(0,0,0,8'h00,0,0, 1, 1,0,8'h00,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].pv, vecs[i].pi, vecs[i].ps, vecs[i].pr);
      if (vecs[i].chk) begin
        check_all(i, vecs[i].e_prdy, vecs[i].e_pvld, vecs[i].e_pi, vecs[i].e_ps, vecs[i].e_cnt);
      end
    end

    // Streaming: prime one word, then push and pop every cycle across several pointer wraps
    drive(0,0,1,8'h01,1'b0,0);
    check_all(1000, 1, BYP, BYP ? 8'h01 : 8'h00, 1'b0, 0);
    for (int k = 1; k < 20; k++) begin
      logic [7:0] w;
      w = 8'(k + 1);
      drive(0,0,1,w,k[0],1);
      check_all(1000 + k, 1, 1, 8'(k), !k[0], 1);
    end
    drive(0,0,0,8'h00,0,1);
    check_all(1020, 1, 1, 8'h14, 1'b1, 1);
    drive(0,0,0,8'h00,0,0);
    check_all(1021, 1, 0, 8'h00, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
